// File: rtl/dual_port_ram_init.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write,
// port-1-priority write collisions and a built-in clear sweep after reset or clr.
module dual_port_ram_init #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 64,
    parameter int               ADDR_BUS   = $clog2(DEPTH),
    parameter int               BE_W       = WIDTH / 8,
    parameter int               RDW_MODE   = 0,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                ready,
    output logic                collision,
    input  logic                en_1,
    input  logic                we_1,
    input  logic [BE_W-1:0]     be_1,
    input  logic [ADDR_BUS-1:0] addr_1,
    input  logic [WIDTH-1:0]    din_1,
    output logic [WIDTH-1:0]    dout_1,
    input  logic                en_2,
    input  logic                we_2,
    input  logic [BE_W-1:0]     be_2,
    input  logic [ADDR_BUS-1:0] addr_2,
    input  logic [WIDTH-1:0]    din_2,
    output logic [WIDTH-1:0]    dout_2
);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    localparam logic [ADDR_BUS:0]   DEPTH_L = (ADDR_BUS + 1)'(DEPTH);
    localparam logic [ADDR_BUS-1:0] LAST    = ADDR_BUS'(DEPTH - 1);

    state_t              state, state_next;
    logic [ADDR_BUS-1:0] cnt;
    logic [WIDTH-1:0]    mem [DEPTH];

    logic             sweep_done, active;
    logic             in_range_1, in_range_2;
    logic             wr_1, wr_2, ww_hit;
    logic [WIDTH-1:0] old_1, old_2;
    logic [WIDTH-1:0] merged_1, merged_2, wdata_1;
    logic [WIDTH-1:0] rd_1, rd_2;

    assign sweep_done = (cnt == LAST);
    assign active     = (state == S_READY) && !clr;

    // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
    assign in_range_1 = ({1'b0, addr_1} < DEPTH_L);
    assign in_range_2 = ({1'b0, addr_2} < DEPTH_L);
    assign old_1      = in_range_1 ? mem[addr_1] : '0;
    assign old_2      = in_range_2 ? mem[addr_2] : '0;

    assign wr_1   = active && en_1 && we_1 && in_range_1;
    assign wr_2   = active && en_2 && we_2 && in_range_2;
    assign ww_hit = active && en_1 && we_1 && en_2 && we_2 && (addr_1 == addr_2);

    // merged_x: own-port byte merge over old data; wdata_1 layers port 1 over
    // port 2's merge when both write the same word, giving port 1 priority.
    always_comb begin
        merged_1 = old_1;
        merged_2 = old_2;
        for (int b = 0; b < BE_W; b++) begin
            if (be_1[b]) merged_1[8*b +: 8] = din_1[8*b +: 8];
            if (be_2[b]) merged_2[8*b +: 8] = din_2[8*b +: 8];
        end
        wdata_1 = (wr_2 && (addr_1 == addr_2)) ? merged_2 : old_1;
        for (int b = 0; b < BE_W; b++) begin
            if (be_1[b]) wdata_1[8*b +: 8] = din_1[8*b +: 8];
        end
    end

    always_comb begin
        rd_1 = old_1;
        rd_2 = old_2;
        if (RDW_MODE == 1 && we_1) rd_1 = merged_1;
        if (RDW_MODE == 1 && we_2) rd_2 = merged_2;
        if (!in_range_1) rd_1 = '0;
        if (!in_range_2) rd_2 = '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_CLEAR: if (sweep_done) state_next = S_READY;
            S_READY: if (clr) state_next = S_CLEAR;
            default: state_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_CLEAR;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            ready     <= 1'b0;
            collision <= 1'b0;
            dout_1    <= '0;
            dout_2    <= '0;
        end else begin
            ready     <= (state_next == S_READY);
            collision <= ww_hit;
            if (state == S_CLEAR && !sweep_done) cnt <= cnt + ADDR_BUS'(1);
            else                                 cnt <= '0;
            if (active && en_1) dout_1 <= rd_1;
            if (active && en_2) dout_2 <= rd_2;
        end
    end

    // Port 1 is written last so it wins a same-address write.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[cnt] <= INIT_VALUE;
        end else begin
            if (wr_2) mem[addr_2] <= merged_2;
            if (wr_1) mem[addr_1] <= wdata_1;
        end
    end

endmodule
